// File: rtl/cc_alu_pkg.sv
// Shared ALU types: compare-flag layout and the issue-stage request record.
package cc_alu_pkg;
  localparam int FLAG_W    = 10;
  localparam int ALU_IDX_W = 3;

  localparam int FLG_GT_S = 0;
  localparam int FLG_LE_S = 1;
  localparam int FLG_GE_S = 2;
  localparam int FLG_LT_S = 3;
  localparam int FLG_GT_U = 4;
  localparam int FLG_LE_U = 5;
  localparam int FLG_GE_U = 6;
  localparam int FLG_LT_U = 7;
  localparam int FLG_NE   = 8;
  localparam int FLG_EQ   = 9;

  typedef struct packed {
    logic [31:0]          op_a;
    logic [31:0]          op_b;
    logic [3:0]           alu_op;
    logic [ALU_IDX_W-1:0] idx;
  } alu_req_t;
endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
interface alu_share_arb_if
  import cc_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op_a;
  logic [NUM_REQ*DATA_W-1:0] req_op_b;
  logic [NUM_REQ*OP_W-1:0]   req_alu_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [NUM_REQ*DATA_W-1:0] rsp_result;
  logic [NUM_REQ*FLAG_W-1:0] rsp_flag;
  logic [FLAG_W-1:0]         last_cmp_flag;
  logic                      last_cmp_valid;
  logic [NUM_REQ-1:0]        busy;

  modport master (
    output req_valid, req_op_a, req_op_b, req_alu_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flag,
           last_cmp_flag, last_cmp_valid, busy
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b, req_alu_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flag,
           last_cmp_flag, last_cmp_valid, busy
  );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; flags always reflect op_a versus op_b regardless of opcode.
`include "cc_alu_defs.sv"
module alu
  import cc_alu_pkg::*;
(
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic [3:0]        alu_op,
  output logic [31:0]       result,
  output logic [FLAG_W-1:0] flag
);
  logic lt_s;
  logic lt_u;
  logic eq;

  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;
  assign eq   = op_a == op_b;

  always_comb begin
    case (alu_op)
      `ALU_SUB, `ALU_CMP: result = op_a - op_b;
      `ALU_AND:           result = op_a & op_b;
      `ALU_OR:            result = op_a | op_b;
      `ALU_XOR:           result = op_a ^ op_b;
      `ALU_SHL:           result = op_a << op_b[4:0];
      `ALU_SHR:           result = op_a >> op_b[4:0];
      default:            result = op_a + op_b;
    endcase
  end

  always_comb begin
    flag           = '0;
    flag[FLG_GT_S] = !lt_s && !eq;
    flag[FLG_LE_S] = lt_s || eq;
    flag[FLG_GE_S] = !lt_s;
    flag[FLG_LT_S] = lt_s;
    flag[FLG_GT_U] = !lt_u && !eq;
    flag[FLG_LE_U] = lt_u || eq;
    flag[FLG_GE_U] = !lt_u;
    flag[FLG_LT_U] = lt_u;
    flag[FLG_NE]   = !eq;
    flag[FLG_EQ]   = eq;
  end
endmodule

// File: rtl/cc_alu_defs.sv
// Shared ALU opcode macros; unknown codes fall through to ADD inside the ALU.
`ifndef CC_ALU_DEFS_SV
`define CC_ALU_DEFS_SV
`define ALU_ADD 4'h0
`define ALU_SUB 4'h1
`define ALU_AND 4'h2
`define ALU_OR  4'h3
`define ALU_XOR 4'h4
`define ALU_CMP 4'h5
`define ALU_SHL 4'h6
`define ALU_SHR 4'h7
`endif

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester at or above pointer, wrapping; combinational.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic found;
  int   c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(pointer) + k) % N;
      if (!found && eligible[IW'(c)]) begin
        found             = 1'b1;
        grant[IW'(c)]     = 1'b1;
        grant_idx         = IW'(c);
      end
    end
  end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NUM_REQ requesters; response 2 edges after accept, one op in flight per requester.
// A requester with an unpopped response is held off unless it pops in the same cycle it re-requests.
`include "cc_alu_defs.sv"
module alu_share_arb
  import cc_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input logic            clk,
  input logic            rst_n,
  alu_share_arb_if.slave bus
);
  logic [NUM_REQ-1:0]        busy_q;
  logic [NUM_REQ-1:0]        rsp_vld_q;
  logic [NUM_REQ*DATA_W-1:0] rsp_res_q;
  logic [NUM_REQ*FLAG_W-1:0] rsp_flg_q;
  logic [IDX_W-1:0]          ptr_q;
  logic                      iss_vld_q;
  alu_req_t                  iss_q;
  logic [FLAG_W-1:0]         last_flg_q;
  logic                      last_vld_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] wb_mask;
  logic               accept;
  alu_req_t           sel_req;
  logic [31:0]        alu_res;
  logic [FLAG_W-1:0]  alu_flag;

  // A popping slot frees up in the same cycle, so pop and re-accept can overlap.
  assign pop      = rsp_vld_q & bus.rsp_ready;
  assign eligible = bus.req_valid & (~busy_q | pop);
  assign accept   = |grant;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .eligible  (eligible),
    .pointer   (ptr_q),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_req.op_a   = bus.req_op_a[i*DATA_W +: DATA_W];
        sel_req.op_b   = bus.req_op_b[i*DATA_W +: DATA_W];
        sel_req.alu_op = bus.req_alu_op[i*OP_W +: OP_W];
        sel_req.idx    = ALU_IDX_W'(i);
      end
    end
  end

  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wb_mask[i] = iss_vld_q && (iss_q.idx == ALU_IDX_W'(i));
    end
  end

  alu u_alu (
    .op_a   (iss_q.op_a),
    .op_b   (iss_q.op_b),
    .alu_op (iss_q.alu_op),
    .result (alu_res),
    .flag   (alu_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      iss_vld_q  <= 1'b0;
      iss_q      <= '0;
      busy_q     <= '0;
      rsp_vld_q  <= '0;
      rsp_res_q  <= '0;
      rsp_flg_q  <= '0;
      last_flg_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      iss_vld_q <= accept;
      if (accept) begin
        iss_q <= sel_req;
        ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      busy_q    <= (busy_q & ~pop) | grant;
      rsp_vld_q <= (rsp_vld_q & ~pop) | wb_mask;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (wb_mask[i]) begin
          rsp_res_q[i*DATA_W +: DATA_W] <= alu_res;
          rsp_flg_q[i*FLAG_W +: FLAG_W] <= alu_flag;
        end
      end
      if (iss_vld_q && (iss_q.alu_op == `ALU_CMP)) begin
        last_flg_q <= alu_flag;
        last_vld_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready      = grant;
  assign bus.rsp_valid      = rsp_vld_q;
  assign bus.rsp_result     = rsp_res_q;
  assign bus.rsp_flag       = rsp_flg_q;
  assign bus.last_cmp_flag  = last_flg_q;
  assign bus.last_cmp_valid = last_vld_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: drivers push expected responses, a negedge monitor pops and compares.
module tb_alu_share_arb;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;

  typedef struct {
    logic [31:0] res;
    logic [9:0]  flg;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[4][$];
  int   gl_idx[$];
  int   gl_cyc[$];
  bit [3:0] held;
  int   exp_order[5] = '{0, 1, 2, 3, 0};

  alu_share_arb_if #(.NUM_REQ(4), .DATA_W(32), .OP_W(4)) bus ();

  alu_share_arb #(.NUM_REQ(4), .DATA_W(32), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] er, input logic [9:0] ef);
    int waited = 0;
    bus.req_op_a[i*32 +: 32]  = a;
    bus.req_op_b[i*32 +: 32]  = b;
    bus.req_alu_op[i*4 +: 4]  = op;
    bus.req_valid[i]          = 1'b1;
    @(negedge clk);
    while (!bus.req_ready[i] && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready[i]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout req=%0d actual=no_grant required=grant", i);
    end else begin
      exp_q[i].push_back('{res: er, flg: ef, due: cyc + 2});
      gl_idx.push_back(i);
      gl_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.rsp_valid[i]) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL rsp_unexpected req=%0d actual=valid required=idle", i);
            end else begin
              e = exp_q[i][0];
              if (!held[i]) chk($sformatf("rsp_latency_%0d", i), 128'(cyc), 128'(e.due));
              chk($sformatf("rsp_result_%0d", i), 128'(bus.rsp_result[i*32 +: 32]), 128'(e.res));
              chk($sformatf("rsp_flag_%0d", i), 128'(bus.rsp_flag[i*10 +: 10]), 128'(e.flg));
              if (bus.rsp_ready[i]) void'(exp_q[i].pop_front());
            end
          end
          held[i] = bus.rsp_valid[i] && !bus.rsp_ready[i];
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 0);
    chk({tag, "_busy"}, 128'(bus.busy), 0);
    chk({tag, "_req_ready"}, 128'(bus.req_ready), 0);
    chk({tag, "_last_cmp_flag"}, 128'(bus.last_cmp_flag), 0);
    chk({tag, "_last_cmp_valid"}, 128'(bus.last_cmp_valid), 0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 0);
    chk({tag, "_rsp_flag"}, 128'(bus.rsp_flag), 0);
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.req_valid  = '0;
    bus.req_op_a   = '0;
    bus.req_op_b   = '0;
    bus.req_alu_op = '0;
    bus.rsp_ready  = 4'hF;
    held           = '0;
    #2 rst_n = 1'b0;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    settle(1);

    // Reset while an op sits in the issue stage: it must vanish, pointer back to 0.
    issue(1, 32'd1, 32'd2, OP_ADD, 32'd3, 10'h1AA);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    #1;
    chk("rst_mid_busy", 128'(bus.busy), 0);
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 128'(bus.rsp_valid), 0);
    end
    settle(1);
    gl_idx.delete();
    gl_cyc.delete();
    fork
      issue(1, 32'd4, 32'd4, OP_ADD, 32'd8, 10'h266);
      issue(2, 32'd9, 32'd1, OP_SUB, 32'd8, 10'h155);
    join
    chk("rst_ptr_first_grant", 128'(gl_idx[0]), 1);
    settle(4);

    // Single ADD with wraparound, busy tracking across pop.
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 10'h15A);
    chk("add_busy_set", 128'(bus.busy[0]), 1);
    settle(1);
    chk("add_rsp_valid", 128'(bus.rsp_valid[0]), 1);
    settle(1);
    chk("add_busy_clear", 128'(bus.busy[0]), 0);
    chk("add_rsp_popped", 128'(bus.rsp_valid[0]), 0);

    issue(2, 32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE, 10'h1AA);
    settle(3);

    issue(1, 32'd5, 32'd7, OP_CMP, 32'hFFFF_FFFE, 10'h1AA);
    settle(3);
    chk("cmp1_last_flag", 128'(bus.last_cmp_flag), 128'h1AA);
    chk("cmp1_last_valid", 128'(bus.last_cmp_valid), 1);

    issue(3, 32'h8000_0000, 32'h0000_0001, OP_CMP, 32'h7FFF_FFFF, 10'h15A);
    settle(3);
    chk("cmp2_last_flag", 128'(bus.last_cmp_flag), 128'h15A);

    // Contention: all four at once, requester 0 comes back for a second op.
    gl_idx.delete();
    gl_cyc.delete();
    fork
      begin
        issue(0, 32'd2, 32'd3, OP_ADD, 32'd5, 10'h1AA);
        issue(0, 32'd10, 32'd4, OP_SUB, 32'd6, 10'h155);
      end
      issue(1, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 32'h0000_F000, 10'h1AA);
      issue(2, 32'd5, 32'd5, OP_XOR, 32'd0, 10'h266);
      issue(3, 32'h10, 32'h01, OP_OR, 32'h11, 10'h155);
    join
    settle(4);
    chk("cont_grant_count", 128'(gl_idx.size()), 5);
    if (gl_idx.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("cont_grant_order_%0d", k), 128'(gl_idx[k]), 128'(exp_order[k]));
        chk($sformatf("cont_grant_cycle_%0d", k), 128'(gl_cyc[k] - gl_cyc[0]), 128'(k));
      end
    end
    chk("noncmp_keeps_last_flag", 128'(bus.last_cmp_flag), 128'h15A);

    // Backpressure on requester 0, then a same-edge pop and accept.
    bus.rsp_ready[0] = 1'b0;
    issue(0, 32'd1, 32'd1, OP_ADD, 32'd2, 10'h266);
    settle(2);
    fork
      issue(0, 32'h0000_00A0, 32'h0000_000B, OP_OR, 32'h0000_00AB, 10'h155);
      issue(1, 32'd7, 32'd8, OP_ADD, 32'd15, 10'h1AA);
      issue(3, 32'd1, 32'd2, OP_SUB, 32'hFFFF_FFFF, 10'h1AA);
      begin
        repeat (6) begin
          @(negedge clk);
          chk("bp_req_ready_low", 128'(bus.req_ready[0]), 0);
          chk("bp_result_held", 128'(bus.rsp_result[31:0]), 2);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_overlap_ready", 128'({bus.req_ready[0], bus.rsp_valid[0]}), 128'b11);
        @(posedge clk);
        #1;
        chk("bp_overlap_busy", 128'(bus.busy[0]), 1);
        chk("bp_overlap_popped", 128'(bus.rsp_valid[0]), 0);
      end
    join
    settle(5);
    chk("drain_all", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 0);

    rst_n = 1'b0;
    #1;
    chk_all_zero("final_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
